// File: rtl/adc_pkg.sv
// adc_pkg: shared FSM state, channel-select type and packed-word helpers for the ADC capture block.
package adc_pkg;
  localparam int WORD_W = 64;
  localparam int SAMP_W = 14;
  typedef enum logic [2:0] {
    S_IDLE,
    S_PRETRIG,
    S_WAIT_TRIG,
    S_POSTTRIG,
    S_READOUT
  } state_t;
  typedef enum logic [1:0] {
    CH_ADC1,
    CH_ADC2,
    CH_ADC4,
    CH_ADC8
  } ch_sel_t;
  function automatic logic [WORD_W-1:0] pack_word(
    input logic [15:0] a1,
    input logic [SAMP_W-1:0] a2,
    input logic [SAMP_W-1:0] a4,
    input logic [SAMP_W-1:0] a8
  );
    return {2'b0, a8, 2'b0, a4, 2'b0, a2, a1};
  endfunction
endpackage

// File: rtl/capture_ram.sv
// capture_ram: simple dual-port ring-buffer storage, one write port and one registered read port.
module capture_ram
  import adc_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [WORD_W-1:0] o_rdata
);
  logic [WORD_W-1:0] r_mem [DEPTH];
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/adc_trig_capture.sv
// adc_trig_capture: pre/post-trigger ADC capture into a ring buffer, streamed out over a valid/ready port.
// Defining ADC_CAP_SW_TRIG_EN adds the sw_trig input, which forces a trigger while waiting for one.
module adc_trig_capture
  import adc_pkg::*;
#(
  parameter int DEPTH    = 1024,
  parameter int PRE_TRIG = 256
) (
  input  logic              CLKDIV,
  input  logic              RST,
  input  logic              aligned,
  input  logic [15:0]       adc1,
  input  logic [SAMP_W-1:0] adc2,
  input  logic [SAMP_W-1:0] adc4,
  input  logic [SAMP_W-1:0] adc8,
  input  logic              arm,
  input  logic [1:0]        trig_ch,
  input  logic [SAMP_W-1:0] threshold,
`ifdef ADC_CAP_SW_TRIG_EN
  input  logic              sw_trig,
`endif
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int AW   = $clog2(DEPTH);
  localparam int POST = DEPTH - PRE_TRIG;
  state_t            r_state, w_next;
  logic [AW-1:0]     r_wptr, r_taddr, r_rptr, w_taddr;
  logic [AW:0]       r_cnt, r_rcnt;
  logic [SAMP_W-1:0] r_prev, w_sel;
  logic              r_prev_vld;
  logic              r_s1_vld, r_s1_last;
  logic [WORD_W-1:0] r_mdata, w_word, w_rdata;
  logic              r_mvalid, r_mlast, r_done, r_err;
  ch_sel_t           w_ch;
  logic              w_cap, w_wr, w_abort, w_cross, w_trig, w_start;
  logic              w_pre_done, w_post_done, w_out_ok, w_issue, w_xfer_last, w_enter_rd;
  assign w_ch   = ch_sel_t'(trig_ch);
  assign w_sel  = (w_ch == CH_ADC1) ? adc1[15:2] :
                  (w_ch == CH_ADC2) ? adc2 :
                  (w_ch == CH_ADC4) ? adc4 : adc8;
  assign w_word = pack_word(adc1, adc2, adc4, adc8);
  assign w_cap   = (r_state == S_PRETRIG) || (r_state == S_WAIT_TRIG) || (r_state == S_POSTTRIG);
  assign w_wr    = w_cap && aligned;
  assign w_abort = w_cap && !aligned;
  assign w_start = (r_state == S_IDLE) && arm && aligned;
  assign w_cross = r_prev_vld && (r_prev < threshold) && (w_sel >= threshold);
`ifdef ADC_CAP_SW_TRIG_EN
  assign w_trig  = (r_state == S_WAIT_TRIG) && aligned && (w_cross || sw_trig);
`else
  assign w_trig  = (r_state == S_WAIT_TRIG) && aligned && w_cross;
`endif
  assign w_pre_done  = r_cnt == (AW+1)'(PRE_TRIG - 1);
  assign w_post_done = r_cnt == (AW+1)'(POST - 1);
  // A trigger that is also the only post-trigger word goes straight to readout, so use the live pointer.
  assign w_taddr     = (r_state == S_WAIT_TRIG) ? r_wptr : r_taddr;
  assign w_out_ok    = !r_mvalid || m_ready;
  assign w_issue     = (r_state == S_READOUT) && (r_rcnt != (AW+1)'(DEPTH)) && (!r_s1_vld || w_out_ok);
  assign w_xfer_last = r_mvalid && m_ready && r_mlast;
  assign w_enter_rd  = (w_next == S_READOUT) && (r_state != S_READOUT);
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      w_next = w_start ? S_PRETRIG : S_IDLE;
      S_PRETRIG:   w_next = !aligned ? S_IDLE : w_pre_done ? S_WAIT_TRIG : S_PRETRIG;
      S_WAIT_TRIG: w_next = !aligned ? S_IDLE : !w_trig ? S_WAIT_TRIG : (POST == 1) ? S_READOUT : S_POSTTRIG;
      S_POSTTRIG:  w_next = !aligned ? S_IDLE : w_post_done ? S_READOUT : S_POSTTRIG;
      S_READOUT:   w_next = w_xfer_last ? S_IDLE : S_READOUT;
      default:     w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge CLKDIV or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end
  always_ff @(posedge CLKDIV or posedge RST) begin
    if (RST) begin
      r_wptr     <= '0;
      r_cnt      <= '0;
      r_taddr    <= '0;
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_start) begin
        r_wptr     <= '0;
        r_cnt      <= '0;
        r_prev_vld <= 1'b0;
        r_done     <= 1'b0;
        r_err      <= 1'b0;
      end
      if (w_abort) r_err <= 1'b1;
      if (w_wr) begin
        r_wptr     <= r_wptr + 1'b1;
        r_cnt      <= r_cnt + 1'b1;
        r_prev     <= w_sel;
        r_prev_vld <= 1'b1;
      end
      if (w_trig) begin
        r_taddr <= r_wptr;
        r_cnt   <= (AW+1)'(1);
      end
      if (w_xfer_last) r_done <= 1'b1;
    end
  end
  // Two-stage read pipe: RAM output register, then the output register that holds during stalls.
  always_ff @(posedge CLKDIV or posedge RST) begin
    if (RST) begin
      r_rptr    <= '0;
      r_rcnt    <= '0;
      r_s1_vld  <= 1'b0;
      r_s1_last <= 1'b0;
      r_mdata   <= '0;
      r_mvalid  <= 1'b0;
      r_mlast   <= 1'b0;
    end else begin
      if (w_enter_rd) begin
        r_rptr   <= w_taddr - AW'(PRE_TRIG);
        r_rcnt   <= '0;
        r_s1_vld <= 1'b0;
      end else begin
        if (w_issue) begin
          r_rptr    <= r_rptr + 1'b1;
          r_rcnt    <= r_rcnt + 1'b1;
          r_s1_last <= r_rcnt == (AW+1)'(DEPTH - 1);
        end
        r_s1_vld <= w_issue ? 1'b1 : w_out_ok ? 1'b0 : r_s1_vld;
      end
      if (w_out_ok) begin
        r_mvalid <= r_s1_vld;
        r_mlast  <= r_s1_vld && r_s1_last;
        if (r_s1_vld) r_mdata <= w_rdata;
      end
    end
  end
  capture_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .i_clk  (CLKDIV),
    .i_we   (w_wr),
    .i_waddr(r_wptr),
    .i_wdata(w_word),
    .i_re   (w_issue),
    .i_raddr(r_rptr),
    .o_rdata(w_rdata)
  );
  assign m_data  = r_mdata;
  assign m_valid = r_mvalid;
  assign m_last  = r_mlast;
  assign busy    = r_state != S_IDLE;
  assign done    = r_done;
  assign err     = r_err;
endmodule

// File: tb/tb_adc_trig_capture.sv
// tb_adc_trig_capture: directed capture vectors plus abort/reset corner sequences, DEPTH=16, PRE_TRIG=4.
module tb_adc_trig_capture;
  localparam int DEPTH = 16;
  localparam int PRE   = 4;
  logic        clk = 1'b0, rst = 1'b1, aligned = 1'b0, arm = 1'b0, m_ready = 1'b0;
  logic [15:0] adc1 = '0;
  logic [13:0] adc2 = '0, adc4 = '0, adc8 = '0, threshold = '0;
  logic [1:0]  trig_ch = '0;
`ifdef ADC_CAP_SW_TRIG_EN
  logic        sw_trig = 1'b0;
`endif
  logic [63:0] m_data;
  logic        m_valid, m_last, busy, done, err;
  int          n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  adc_trig_capture #(.DEPTH(DEPTH), .PRE_TRIG(PRE)) dut (
    .CLKDIV(clk), .RST(rst), .aligned(aligned),
    .adc1(adc1), .adc2(adc2), .adc4(adc4), .adc8(adc8),
    .arm(arm), .trig_ch(trig_ch), .threshold(threshold),
`ifdef ADC_CAP_SW_TRIG_EN
    .sw_trig(sw_trig),
`endif
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .done(done), .err(err)
  );
  // Sample k of a run: hold_v for the first hold_n cycles, then a ramp from 0.
  typedef struct {
    int ch; int thr; int hold_n; int hold_v; bit stall; int sw_k; int exp_trig; int exp_first;
  } vec_t;
  vec_t vecs[$];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic int samp(input vec_t v, input int c);
    return (c < v.hold_n) ? v.hold_v : c - v.hold_n;
  endfunction
  function automatic logic [63:0] word_of(input int r);
    return {2'b0, 14'(r + 300), 2'b0, 14'(r + 200), 2'b0, 14'(r), 14'(r + 50), 2'b11};
  endfunction
  task automatic set_adc(input int r);
    adc1 = {14'(r + 50), 2'b11};
    adc2 = 14'(r);
    adc4 = 14'(r + 200);
    adc8 = 14'(r + 300);
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic arm_cycle();
    arm = 1'b1;
    aligned = 1'b1;
    tick();
    arm = 1'b0;
  endtask
  task automatic run_capture(input vec_t v, input int stop_at);
    int got = 0;
    bit fin = 0, held = 0, seen = 0, rdy;
    logic [63:0] hd;
    logic hl;
    trig_ch = 2'(v.ch);
    threshold = 14'(v.thr);
    set_adc(0);
    arm_cycle();
    for (int c = 0; c < 400 && !fin && got != stop_at; c++) begin
      if (held) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, hd);
        check("stall_last", m_last, hl);
      end
      if (m_valid && !seen) begin
        seen = 1;
        check("first_valid_latency", c <= v.exp_trig + 15, 1);
      end
      rdy = v.stall ? c[0] : 1'b1;
      m_ready = rdy;
      set_adc(samp(v, c));
`ifdef ADC_CAP_SW_TRIG_EN
      sw_trig = (c == v.sw_k);
`endif
      if (m_valid && rdy) begin
        if (got == 0) check("first_adc2", m_data[29:16], 64'(v.exp_first));
        check("word", m_data, word_of(samp(v, v.exp_trig - PRE + got)));
        check("last", m_last, got == DEPTH - 1);
        got++;
        fin = got == DEPTH;
      end
      held = m_valid && !rdy;
      hd = m_data;
      hl = m_last;
      tick();
    end
`ifdef ADC_CAP_SW_TRIG_EN
    sw_trig = 1'b0;
`endif
    if (stop_at > DEPTH) begin
      check("complete", fin, 1);
      check("done_after", done, 1);
      check("busy_after", busy, 0);
      check("valid_after", m_valid, 0);
      check("err_after", err, 0);
    end
  endtask
  initial begin
    bit seen;
    vecs.push_back('{ch:1, thr:10,  hold_n:0, hold_v:0,  stall:0, sw_k:-1, exp_trig:10, exp_first:6});
    vecs.push_back('{ch:1, thr:10,  hold_n:0, hold_v:0,  stall:1, sw_k:-1, exp_trig:10, exp_first:6});
    vecs.push_back('{ch:1, thr:10,  hold_n:8, hold_v:20, stall:0, sw_k:-1, exp_trig:18, exp_first:6});
    vecs.push_back('{ch:0, thr:57,  hold_n:0, hold_v:0,  stall:0, sw_k:-1, exp_trig:7,  exp_first:3});
    vecs.push_back('{ch:2, thr:205, hold_n:0, hold_v:0,  stall:0, sw_k:-1, exp_trig:5,  exp_first:1});
    vecs.push_back('{ch:3, thr:315, hold_n:0, hold_v:0,  stall:1, sw_k:-1, exp_trig:15, exp_first:11});
    vecs.push_back('{ch:1, thr:4,   hold_n:0, hold_v:0,  stall:0, sw_k:-1, exp_trig:4,  exp_first:0});
`ifdef ADC_CAP_SW_TRIG_EN
    vecs.push_back('{ch:1, thr:10, hold_n:1000, hold_v:0, stall:0, sw_k:8, exp_trig:8, exp_first:0});
`endif
    repeat (3) @(negedge clk);
    check("rst_valid", m_valid, 0);
    check("rst_last", m_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_data", m_data, 0);
    rst = 1'b0;
    aligned = 1'b1;
    tick();
    foreach (vecs[i]) begin
      run_capture(vecs[i], DEPTH + 1);
      repeat (2) tick();
    end
    // A level held above threshold is not a rising crossing.
    trig_ch = 2'd1;
    threshold = 14'd10;
    set_adc(20);
    arm_cycle();
    seen = 0;
    repeat (40) begin
      tick();
      seen |= m_valid;
    end
    check("const_busy", busy, 1);
    check("const_no_valid", seen, 0);
    check("const_done_cleared", done, 0);
    aligned = 1'b0;
    tick();
    check("const_abort_err", err, 1);
    check("const_abort_busy", busy, 0);
    aligned = 1'b1;
    tick();
    // Alignment loss during post-trigger capture aborts the run.
    set_adc(0);
    arm_cycle();
    check("rearm_err_cleared", err, 0);
    for (int c = 0; c <= 13; c++) begin
      set_adc(c);
      aligned = (c != 13);
      tick();
    end
    check("post_abort_err", err, 1);
    check("post_abort_busy", busy, 0);
    aligned = 1'b1;
    seen = 0;
    repeat (30) begin
      tick();
      seen |= m_valid;
    end
    check("post_abort_no_valid", seen, 0);
    run_capture(vecs[0], DEPTH + 1);
    tick();
    // Asynchronous reset in the middle of readout.
    run_capture(vecs[0], 5);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_last", m_last, 0);
    check("mid_rst_data", m_data, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    run_capture(vecs[4], DEPTH + 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
